// File: rtl/lr_pkg.sv
// Shared constants, FSM encoding and field/byte offset helpers for the
// linear-regression stream loader.
package lr_pkg;

    localparam int unsigned MAX_FEATURES = 6;
    localparam int unsigned FIELD_W      = 16;
    localparam int unsigned WORD_WIDTH   = FIELD_W * (MAX_FEATURES + 1);

    // Gray-coded so adjacent states differ in a single bit, as in the core.
    typedef enum logic [2:0] {
        StLoad    = 3'b000,
        StRun     = 3'b001,
        StCapture = 3'b011,
        StSend    = 3'b010,
        StDone    = 3'b110
    } state_e;

    // Fields are left-aligned in the word: field 0 (bias/y) occupies the top 16 bits.
    function automatic int unsigned field_lsb(input int unsigned k);
        return WORD_WIDTH - FIELD_W * (k + 1);
    endfunction

    function automatic int unsigned byte_lsb(input int unsigned i);
        return WORD_WIDTH - 8 * (i + 1);
    endfunction

endpackage

// File: rtl/lr_stream_loader_if.sv
// Host byte streams plus the core-side control/address signals of the loader.
interface lr_stream_loader_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  lr_enable;
    logic                  fin_final;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  done;

    modport master (
        output rx_data, rx_valid, addr, fin_final, tx_ready,
        input  rx_ready, lr_enable, tx_data, tx_valid, done
    );

    modport slave (
        input  rx_data, rx_valid, addr, fin_final, tx_ready,
        output rx_ready, lr_enable, tx_data, tx_valid, done
    );
endinterface

// File: rtl/dp_ram.sv
// Word RAM: synchronous write, asynchronous read, out-of-range reads return zero.
module dp_ram #(
    parameter int unsigned Depth     = 7,
    parameter int unsigned AddrWidth = 3,
    parameter int unsigned Width     = 112
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < Depth)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (32'(raddr_i) < Depth) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/lr_stream_loader.sv
// Loads training words from a host byte stream, serves them on the core's temp bus,
// then captures the final weights and streams them back byte-wise.
module lr_stream_loader
    import lr_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = 6,
    parameter int unsigned DPS          = 6,
    parameter int unsigned ADDR_WIDTH   = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    lr_stream_loader_if.slave             bus,
    inout  wire signed [WORD_WIDTH-1:0]   temp
);

    localparam int unsigned B        = 2 * (NUM_FEATURES + 1);
    localparam int unsigned CntW     = $clog2(B);
    localparam int unsigned PadW     = field_lsb(NUM_FEATURES);
    localparam logic [CntW-1:0] LastByte = CntW'(B - 1);

    state_e state_q, state_d;
    logic   rx_ready_q, rx_ready_d;
    logic   lr_enable_q, lr_enable_d;
    logic   done_q, done_d;

    logic [CntW-1:0]       byte_cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [WORD_WIDTH-9:0] pack_q;
    logic [WORD_WIDTH-1:0] pack_shift, wr_data, rd_data, wt_q;
    logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  rx_fire, wr_en, last_word, tx_last;

    assign rx_fire    = rx_ready_q & bus.rx_valid;
    assign pack_shift = {pack_q, bus.rx_data};
    // Left-align the packed bytes; stale bytes of earlier words fall off the top.
    assign wr_data    = pack_shift << PadW;
    assign wr_en      = rx_fire && (byte_cnt_q == LastByte);
    assign last_word  = wr_en && (wr_ptr_q == ADDR_WIDTH'(DPS));
    assign tx_last    = (tx_cnt_q == LastByte);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StLoad;
            rx_ready_q  <= 1'b0;
            lr_enable_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            lr_enable_q <= lr_enable_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:    if (last_word) state_d = StRun;
            StRun:     if (bus.fin_final) state_d = StCapture;
            StCapture: state_d = StSend;
            StSend:    if (tx_valid_q && bus.tx_ready && tx_last) state_d = StDone;
            StDone:    state_d = StDone;
            default:   state_d = StLoad;
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_comb begin
        rx_ready_d  = (state_d == StLoad);
        lr_enable_d = (state_d == StRun);
        done_d      = (state_d == StDone);
    end

    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (state_q == StCapture) begin
            tx_cnt_d   = '0;
            tx_valid_d = 1'b0;
        end else if (state_q == StSend) begin
            if (!tx_valid_q) begin
                tx_data_d  = 8'(wt_q >> byte_lsb(32'(tx_cnt_q)));
                tx_valid_d = 1'b1;
            end else if (bus.tx_ready) begin
                if (tx_last) begin
                    tx_valid_d = 1'b0;
                end else begin
                    tx_cnt_d  = tx_cnt_q + 1'b1;
                    tx_data_d = 8'(wt_q >> byte_lsb(32'(tx_cnt_d)));
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            pack_q     <= '0;
            wt_q       <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            if (rx_fire) begin
                pack_q     <= pack_shift[WORD_WIDTH-9:0];
                byte_cnt_q <= wr_en ? '0 : byte_cnt_q + 1'b1;
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
            if (state_q == StCapture) begin
                wt_q <= temp;
            end
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    dp_ram #(
        .Depth     (DPS + 1),
        .AddrWidth (ADDR_WIDTH),
        .Width     (WORD_WIDTH)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (bus.addr),
        .rdata_o (rd_data)
    );

    // Released combinationally on fin_final so the core can drive the bus the same cycle.
    assign temp = (lr_enable_q && !bus.fin_final) ? rd_data : {WORD_WIDTH{1'bz}};

    assign bus.rx_ready  = rx_ready_q;
    assign bus.lr_enable = lr_enable_q;
    assign bus.done      = done_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_lr_stream_loader.sv
// Randomised self-checking bench for lr_stream_loader against a field-level word model.
module tb_lr_stream_loader;
    import lr_pkg::*;

    localparam int unsigned W = WORD_WIDTH;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    lr_stream_loader_if #(.ADDR_WIDTH(3)) bus ();
    lr_stream_loader_if #(.ADDR_WIDTH(3)) bus4 ();

    wire signed [W-1:0] temp;
    wire signed [W-1:0] temp4;
    logic               tb_drv  = 1'b0;
    logic [W-1:0]       tb_temp = '0;
    assign temp = tb_drv ? tb_temp : {W{1'bz}};

    lr_stream_loader #(.NUM_FEATURES(6), .DPS(6), .ADDR_WIDTH(3)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .temp (temp)
    );

    lr_stream_loader #(.NUM_FEATURES(4), .DPS(6), .ADDR_WIDTH(3)) dut4 (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus4),
        .temp (temp4)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] fld [7][7];

    // Reference word: field k placed in the k-th 16-bit slot from the top, rest zero.
    function automatic logic [W-1:0] word_of(input int w, input int nf);
        logic [W-1:0] r = '0;
        for (int k = 0; k <= nf; k++) r |= W'(fld[w][k]) << (W - 16 * (k + 1));
        return r;
    endfunction

    task automatic fill_plan();
        for (int w = 0; w < 7; w++)
            for (int k = 0; k < 7; k++)
                fld[w][k] = (w == 0) ? 16'h0040 : 16'(16'h0100 * w);
    endtask

    task automatic fill_random();
        for (int w = 0; w < 7; w++)
            for (int k = 0; k < 7; k++) fld[w][k] = 16'($urandom);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.rx_valid = 1'b0; bus.fin_final = 1'b0; bus.tx_ready = 1'b0; bus.addr = '0;
        bus4.rx_valid = 1'b0; bus4.fin_final = 1'b0; bus4.tx_ready = 1'b0; bus4.addr = '0;
        tb_drv = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input int max_gap);
        int   gap, n;
        logic ok;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (gap > 0) begin
            if (sel != 0) bus4.rx_valid = 1'b0; else bus.rx_valid = 1'b0;
            repeat (gap) @(negedge CLK);
        end
        if (sel != 0) begin bus4.rx_data = b; bus4.rx_valid = 1'b1; end
        else begin bus.rx_data = b; bus.rx_valid = 1'b1; end
        ok = 1'b0;
        n  = 0;
        while (!ok && n <= 50) begin
            ok = (sel != 0) ? bus4.rx_ready : bus.rx_ready;
            @(negedge CLK);
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rx_accept_timeout got no rx_ready want rx_ready within 50 cycles");
        end
    endtask

    task automatic load_words(input int sel, input int nf, input int max_gap);
        for (int w = 0; w < 7; w++)
            for (int k = 0; k <= nf; k++) begin
                send_byte(sel, fld[w][k][15:8], max_gap);
                send_byte(sel, fld[w][k][7:0], max_gap);
            end
        if (sel != 0) bus4.rx_valid = 1'b0; else bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.rx_valid = 1'b0; bus.fin_final = 1'b0; bus.tx_ready = 1'b0; bus.addr = '0;
        bus.rx_data = '0;
        bus4.rx_valid = 1'b0; bus4.fin_final = 1'b0; bus4.tx_ready = 1'b0; bus4.addr = '0;
        bus4.rx_data = '0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.rx_ready !== 1'b0) begin errors++;
            $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
        checks++; if (bus.lr_enable !== 1'b0) begin errors++;
            $display("FAIL reset_lr_enable got %b want 0", bus.lr_enable); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++;
            $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++;
            $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.rx_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_rx_ready got %b want 1", bus.rx_ready); end
    endtask

    task automatic test_load();
        logic [W-1:0] exp;
        do_reset();
        fill_plan();
        load_words(0, 6, 0);
        checks++; if (bus.lr_enable !== 1'b1) begin errors++;
            $display("FAIL load_lr_enable got %b want 1", bus.lr_enable); end
        checks++; if (bus.rx_ready !== 1'b0) begin errors++;
            $display("FAIL load_rx_ready_low got %b want 0", bus.rx_ready); end
        for (int a = 0; a < 8; a++) begin
            bus.addr = 3'(a);
            #1;
            exp = (a <= 6) ? word_of(a, 6) : '0;
            checks++; if (temp !== exp) begin errors++;
                $display("FAIL load_word%0d got %h want %h", a, temp, exp); end
        end
        @(negedge CLK);
    endtask

    task automatic test_random_load();
        do_reset();
        fill_random();
        load_words(0, 6, 3);
        for (int a = 0; a < 7; a++) begin
            bus.addr = 3'(a);
            #1;
            checks++; if (temp !== word_of(a, 6)) begin errors++;
                $display("FAIL rand_word%0d got %h want %h", a, temp, word_of(a, 6)); end
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_plan();
        load_words(0, 6, 4);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rx_ready !== 1'b0) begin errors++;
                $display("FAIL extra_byte_ready got %b want 0", bus.rx_ready); end
            @(negedge CLK);
        end
        bus.rx_valid = 1'b0;
        checks++; if (bus.lr_enable !== 1'b1) begin errors++;
            $display("FAIL bp_lr_enable got %b want 1", bus.lr_enable); end
        for (int a = 0; a < 7; a++) begin
            bus.addr = 3'(a);
            #1;
            checks++; if (temp !== word_of(a, 6)) begin errors++;
                $display("FAIL bp_word%0d got %h want %h", a, temp, word_of(a, 6)); end
        end
        @(negedge CLK);
    endtask

    task automatic test_capture_send(input bit rand_word, input bit stall);
        logic [15:0]  cap [7];
        logic [7:0]   exp_b [14];
        logic [7:0]   got [$];
        logic [W-1:0] cw;
        int           cyc, stall_left;
        do_reset();
        fill_random();
        load_words(0, 6, 2);
        cw = '0;
        for (int k = 0; k < 7; k++) begin
            cap[k] = rand_word ? 16'($urandom) : 16'(16'h0011 * (k + 1));
            exp_b[2 * k]     = cap[k][15:8];
            exp_b[2 * k + 1] = cap[k][7:0];
            cw |= W'(cap[k]) << (W - 16 * (k + 1));
        end
        tb_temp = cw; tb_drv = 1'b1; bus.fin_final = 1'b1; bus.tx_ready = 1'b0;
        @(negedge CLK);
        checks++; if (bus.lr_enable !== 1'b0) begin errors++;
            $display("FAIL cap_lr_enable_drop got %b want 0", bus.lr_enable); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL cap_tx_early1 got %b want 0", bus.tx_valid); end
        @(negedge CLK);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL cap_tx_early2 got %b want 0", bus.tx_valid); end
        @(negedge CLK);
        checks++; if (bus.tx_valid !== 1'b1) begin errors++;
            $display("FAIL cap_tx_first_valid got %b want 1", bus.tx_valid); end
        checks++; if (bus.tx_data !== exp_b[0]) begin errors++;
            $display("FAIL cap_tx_first_data got %h want %h", bus.tx_data, exp_b[0]); end
        stall_left = 5;
        cyc = 0;
        while (got.size() < 14 && cyc < 300) begin
            if (bus.tx_valid) begin
                if (stall && got.size() == 3 && stall_left > 0) begin
                    checks++; if (bus.tx_data !== exp_b[3]) begin errors++;
                        $display("FAIL tx_stall_hold got %h want %h", bus.tx_data, exp_b[3]); end
                    bus.tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.tx_ready = stall ? 1'b1 : 1'($urandom_range(0, 1));
                end
                if (bus.tx_ready) got.push_back(bus.tx_data);
            end else begin
                bus.tx_ready = 1'($urandom_range(0, 1));
            end
            @(negedge CLK);
            cyc++;
        end
        bus.tx_ready = 1'b0;
        checks++; if (got.size() != 14) begin errors++;
            $display("FAIL tx_count got %0d want 14", got.size()); end
        for (int i = 0; i < got.size() && i < 14; i++) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++;
                $display("FAIL tx_byte%0d got %h want %h", i, got[i], exp_b[i]); end
        end
        if (stall) begin
            checks++; if (cyc != 19) begin errors++;
                $display("FAIL tx_back_to_back got %0d cycles want 19", cyc); end
        end
        checks++; if (bus.done !== 1'b1) begin errors++;
            $display("FAIL tx_done got %b want 1", bus.done); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL tx_valid_after got %b want 0", bus.tx_valid); end
        repeat (3) @(negedge CLK);
        checks++; if (bus.done !== 1'b1) begin errors++;
            $display("FAIL done_hold got %b want 1", bus.done); end
        tb_drv = 1'b0;
        bus.fin_final = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 20; i++) send_byte(0, 8'($urandom), 1);
        bus.rx_valid = 1'b0;
        do_reset();
        fill_random();
        load_words(0, 6, 1);
        checks++; if (bus.lr_enable !== 1'b1) begin errors++;
            $display("FAIL rml_lr_enable got %b want 1", bus.lr_enable); end
        for (int a = 0; a < 7; a++) begin
            bus.addr = 3'(a);
            #1;
            checks++; if (temp !== word_of(a, 6)) begin errors++;
                $display("FAIL rml_word%0d got %h want %h", a, temp, word_of(a, 6)); end
        end
        @(negedge CLK);
    endtask

    task automatic test_nf4();
        do_reset();
        fill_random();
        load_words(1, 4, 2);
        checks++; if (bus4.lr_enable !== 1'b1) begin errors++;
            $display("FAIL nf4_lr_enable got %b want 1", bus4.lr_enable); end
        checks++; if (bus.lr_enable !== 1'b0) begin errors++;
            $display("FAIL nf4_other_idle got %b want 0", bus.lr_enable); end
        for (int a = 0; a < 7; a++) begin
            bus4.addr = 3'(a);
            #1;
            checks++; if (temp4 !== word_of(a, 4)) begin errors++;
                $display("FAIL nf4_word%0d got %h want %h", a, temp4, word_of(a, 4)); end
            checks++; if (temp4[31:0] !== 32'h0) begin errors++;
                $display("FAIL nf4_low_zero%0d got %h want 00000000", a, temp4[31:0]); end
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_load();
        test_random_load();
        test_backpressure();
        test_capture_send(1'b0, 1'b1);
        test_capture_send(1'b1, 1'b0);
        test_reset_mid_load();
        test_nf4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
